// File: rtl/pixel_stream_pkg.sv
// Shared widths, default frame geometry and the buffered pixel entry format.
// Pure declarations; no logic or timing of its own.
// Used by the packer, its bus interface and the bench.
package pixel_stream_pkg;

  localparam int COLOR_W         = 24;
  localparam int X_W             = 10;
  localparam int Y_W             = 9;
  localparam int H_RES_DEF       = 640;
  localparam int V_RES_DEF       = 480;
  localparam int FIFO_DEPTH_DEF  = 16;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic               sof;
    logic               eol;
    logic               eof;
  } pixel_entry_t;

  localparam int ENTRY_W = $bits(pixel_entry_t);

  // Frame markers are resolved at write time so the output side only reads flags.
  function automatic pixel_entry_t make_entry(
    input logic [COLOR_W-1:0] color,
    input logic [X_W-1:0]     x,
    input logic [Y_W-1:0]     y,
    input logic [X_W-1:0]     x_last,
    input logic [Y_W-1:0]     y_last
  );
    pixel_entry_t e;
    e.color = color;
    e.sof   = (x == '0) && (y == '0);
    e.eol   = (x == x_last);
    e.eof   = (x == x_last) && (y == y_last);
    return e;
  endfunction

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Pixel-in / AXI4-Stream-video-out bundle plus status outputs of the packer.
// No logic; slave modport is the packer's view, master is the environment's.
// Backpressure travels on pix_ready (input side) and m_tready (output side).
interface pixel_stream_packer_if #(
  parameter int FIFO_DEPTH = 16
);
  import pixel_stream_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               pix_valid;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_ready;

  logic [COLOR_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tuser;
  logic               m_tlast;

  logic               frame_done;
  logic [LVL_W-1:0]   fill_level;
  logic               range_err;
  logic               seq_err;

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, m_tready,
    output pix_ready, m_tdata, m_tvalid, m_tuser, m_tlast,
           frame_done, fill_level, range_err, seq_err
  );

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, m_tready,
    input  pix_ready, m_tdata, m_tvalid, m_tuser, m_tlast,
           frame_done, fill_level, range_err, seq_err
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// Latency: a push into an empty FIFO is visible on pop_dat/!empty next cycle.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // The extra MSB separates a full ring from an empty one when indices match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Buffers rendered pixels and emits them as AXI4-Stream video; PIXEL_STREAM_SEQ_CHECK_EN adds raster-order checking.
// Latency: pixel accepted at cycle N into an empty buffer appears on m_tvalid at N+1.
// Backpressure: pix_ready drops when the buffer is full; m_tready low holds the head beat.
module pixel_stream_packer
  import pixel_stream_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 sysclk,
  input  logic                 reset,
  pixel_stream_packer_if.slave bus
);

  localparam int             LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  pixel_entry_t       wr_entry;
  pixel_entry_t       rd_entry;

  logic               pix_ready;
  logic               m_tvalid;
  logic               accept;
  logic               in_range;
  logic               push;
  logic               pop;
  logic               seq_err;

  logic               frame_done_q, frame_done_d;
  logic               range_err_q, range_err_d;

  // Held low through reset so nothing is taken while the buffer is being cleared.
  assign pix_ready = !fifo_full && !reset;
  assign m_tvalid  = !fifo_empty;

  always_comb begin
    in_range     = (bus.pix_x <= X_LAST) && (bus.pix_y <= Y_LAST);
    accept       = bus.pix_valid && pix_ready;
    push         = accept && in_range;
    pop          = m_tvalid && bus.m_tready;
    wr_entry     = make_entry(bus.pix_color, bus.pix_x, bus.pix_y, X_LAST, Y_LAST);
    frame_done_d = pop && rd_entry.eof;
    range_err_d  = range_err_q || (accept && !in_range);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
      range_err_q  <= range_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sysclk),
    .rst      (reset),
    .push     (push),
    .push_dat (wr_entry),
    .pop      (pop),
    .pop_dat  (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

`ifdef PIXEL_STREAM_SEQ_CHECK_EN
  logic [X_W-1:0] exp_x_q, exp_x_d;
  logic [Y_W-1:0] exp_y_q, exp_y_d;
  logic           seq_err_q, seq_err_d;

  // On a mismatch the counter follows the received pixel rather than the old expectation.
  always_comb begin
    exp_x_d   = exp_x_q;
    exp_y_d   = exp_y_q;
    seq_err_d = seq_err_q;
    if (push) begin
      if ((bus.pix_x != exp_x_q) || (bus.pix_y != exp_y_q)) begin
        seq_err_d = 1'b1;
      end
      if (bus.pix_x == X_LAST) begin
        exp_x_d = '0;
        exp_y_d = (bus.pix_y == Y_LAST) ? '0 : bus.pix_y + 1'b1;
      end else begin
        exp_x_d = bus.pix_x + 1'b1;
        exp_y_d = bus.pix_y;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      exp_x_q   <= '0;
      exp_y_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_x_q   <= exp_x_d;
      exp_y_q   <= exp_y_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  assign bus.pix_ready  = pix_ready;
  assign bus.m_tvalid   = m_tvalid;
  assign bus.m_tdata    = rd_entry.color;
  assign bus.m_tuser    = rd_entry.sof;
  assign bus.m_tlast    = rd_entry.eol;
  assign bus.frame_done = frame_done_q;
  assign bus.fill_level = fifo_level;
  assign bus.range_err  = range_err_q;
  assign bus.seq_err    = seq_err;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the pixel buffer.
module tb_pixel_stream_packer;
  import pixel_stream_pkg::*;

  localparam int HR    = 32;
  localparam int VR    = 6;
  localparam int DEPTH = 16;
`ifdef PIXEL_STREAM_SEQ_CHECK_EN
  localparam logic [31:0] SEQ_EXP = 32'd1;
`else
  localparam logic [31:0] SEQ_EXP = 32'd0;
`endif

  typedef struct {
    int          x;
    int          y;
    logic [23:0] c;
  } px_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  pixel_stream_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  pixel_stream_packer #(
    .H_RES      (HR),
    .V_RES      (VR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  px_t mq[$];
  bit  fd_exp, re_exp, se_exp, last_acc, chk_en;
  int  exp_idx;
  int  n_chk, n_fail;
  int  beats, tlast_beats, tuser_beats, fd_pulses;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, compare mid-low-phase, then advance the model.
  task automatic cycle(input bit v, input int x, input int y, input logic [23:0] c,
                       input bit rdy, input bit rst);
    bit  acc, popped;
    int  idx;
    px_t e;
    @(negedge sysclk);
    reset         = rst;
    bus.pix_valid = v;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 9'(y);
    bus.pix_color = c;
    bus.m_tready  = rdy;
    #1;
    if (chk_en) begin
      if (rst) begin
        check_val("ready_in_reset", 32'(bus.pix_ready), 32'd0);
      end else begin
        check_val("pix_ready", 32'(bus.pix_ready), 32'(mq.size() < DEPTH));
        check_val("m_tvalid", 32'(bus.m_tvalid), 32'(mq.size() != 0));
        check_val("fill_level", 32'(bus.fill_level), 32'(mq.size()));
        if (mq.size() != 0) begin
          check_val("m_tdata", 32'(bus.m_tdata), 32'(mq[0].c));
          check_val("m_tuser", 32'(bus.m_tuser), 32'(mq[0].x == 0 && mq[0].y == 0));
          check_val("m_tlast", 32'(bus.m_tlast), 32'(mq[0].x == HR - 1));
        end
        check_val("frame_done", 32'(bus.frame_done), 32'(fd_exp));
        check_val("range_err", 32'(bus.range_err), 32'(re_exp));
        check_val("seq_err", 32'(bus.seq_err), 32'(se_exp));
      end
    end
    if (!rst && bus.m_tvalid && rdy) begin
      beats++;
      if (bus.m_tlast) tlast_beats++;
      if (bus.m_tuser) tuser_beats++;
    end
    if (!rst && bus.frame_done) fd_pulses++;

    acc = 1'b0;
    if (rst) begin
      mq.delete();
      fd_exp  = 1'b0;
      re_exp  = 1'b0;
      se_exp  = 1'b0;
      exp_idx = 0;
    end else begin
      acc    = v && (mq.size() < DEPTH);
      popped = rdy && (mq.size() != 0);
      fd_exp = 1'b0;
      if (popped) begin
        e      = mq.pop_front();
        fd_exp = (e.x == HR - 1) && (e.y == VR - 1);
      end
      if (acc) begin
        if (x < HR && y < VR) begin
          mq.push_back('{x: x, y: y, c: c});
          idx = y * HR + x;
`ifdef PIXEL_STREAM_SEQ_CHECK_EN
          if (idx != exp_idx) se_exp = 1'b1;
`endif
          exp_idx = (idx + 1) % (HR * VR);
        end else begin
          re_exp = 1'b1;
        end
      end
    end
    last_acc = acc;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 24'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 0, 0, 24'h0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 24'h0, 1'b0, 1'b1);
    check_val("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    check_val("rst_fill", 32'(bus.fill_level), 32'd0);
    check_val("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check_val("rst_range_err", 32'(bus.range_err), 32'd0);
    check_val("rst_seq_err", 32'(bus.seq_err), 32'd0);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (mq.size() != 0 && g < 400) begin
      cycle(1'b0, 0, 0, 24'h0, 1'b1, 1'b0);
      g++;
    end
    check_val(tag, 32'(mq.size()), 32'd0);
  endtask

  initial begin
    logic [23:0] head_c;
    int px, py, pushed, g;

    chk_en = 1'b0;
    cycle(1'b0, 0, 0, 24'h0, 1'b0, 1'b1);
    chk_en = 1'b1;
    do_reset();
    idle(1, 1'b1);
    check_val("ready_after_rst", 32'(bus.pix_ready), 32'd1);

    // First pixel of a frame falls through on the next cycle.
    cycle(1'b1, 0, 0, 24'hFF0000, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 24'h0, 1'b1, 1'b0);
    check_val("first_tvalid", 32'(bus.m_tvalid), 32'd1);
    check_val("first_tdata", 32'(bus.m_tdata), 32'hFF0000);
    check_val("first_tuser", 32'(bus.m_tuser), 32'd1);
    check_val("first_tlast", 32'(bus.m_tlast), 32'd0);
    idle(1, 1'b1);

    // Fill to capacity under backpressure, offer one more, then release.
    head_c = 24'h123456;
    cycle(1'b1, 1, 0, head_c, 1'b0, 1'b0);
    for (int i = 2; i <= 16; i++) cycle(1'b1, i, 0, 24'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 17, 0, 24'hABCDEF, 1'b0, 1'b0);
    check_val("full_ready", 32'(bus.pix_ready), 32'd0);
    check_val("full_fill", 32'(bus.fill_level), 32'd16);
    idle(3, 1'b0);
    check_val("stall_head", 32'(bus.m_tdata), 32'(head_c));
    check_val("full_fill_after", 32'(bus.fill_level), 32'd16);
    beats = 0;
    idle(20, 1'b1);
    check_val("release_beats", 32'(beats), 32'd16);

    // Out-of-range column is swallowed and flagged.
    beats = 0;
    cycle(1'b1, 640, 5, 24'h777777, 1'b1, 1'b0);
    idle(2, 1'b1);
    check_val("range_flag", 32'(bus.range_err), 32'd1);
    check_val("range_fill", 32'(bus.fill_level), 32'd0);
    check_val("range_beats", 32'(beats), 32'd0);

    // Skipped raster position.
    do_reset();
    beats = 0;
    cycle(1'b1, 0, 0, 24'h010101, 1'b1, 1'b0);
    cycle(1'b1, 2, 0, 24'h020202, 1'b1, 1'b0);
    idle(3, 1'b1);
    check_val("seq_gap", 32'(bus.seq_err), SEQ_EXP);
    check_val("seq_beats", 32'(beats), 32'd2);

    // Reset with a partly filled buffer discards everything.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, i, 0, 24'($urandom), 1'b0, 1'b0);
    idle(1, 1'b0);
    check_val("pre_flush_fill", 32'(bus.fill_level), 32'd8);
    cycle(1'b0, 0, 0, 24'h0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 24'h0, 1'b1, 1'b0);
    check_val("flush_tvalid", 32'(bus.m_tvalid), 32'd0);
    check_val("flush_fill", 32'(bus.fill_level), 32'd0);
    beats = 0;
    idle(10, 1'b1);
    check_val("flush_beats", 32'(beats), 32'd0);

    // Whole frame in raster order with random gaps and ~50% sink readiness.
    do_reset();
    beats = 0; tlast_beats = 0; tuser_beats = 0; fd_pulses = 0;
    px = 0; py = 0; pushed = 0; g = 0;
    while (pushed < HR * VR && g < 5000) begin
      cycle($urandom_range(0, 3) != 0, px, py, 24'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (last_acc) begin
        pushed++;
        px++;
        if (px == HR) begin
          px = 0;
          py++;
        end
      end
      g++;
    end
    check_val("frame_fed", 32'(pushed), 32'(HR * VR));
    drain("frame_drain");
    idle(3, 1'b1);
    check_val("frame_beats", 32'(beats), 32'(HR * VR));
    check_val("frame_tlast", 32'(tlast_beats), 32'(VR));
    check_val("frame_tuser", 32'(tuser_beats), 32'd1);
    check_val("frame_done_cnt", 32'(fd_pulses), 32'd1);
    check_val("frame_seq_err", 32'(bus.seq_err), 32'd0);

    // Random coordinates, including out-of-range and out-of-order ones.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b1, $urandom_range(0, HR + 2), $urandom_range(0, VR), 24'($urandom),
              1'($urandom_range(0, 1)), 1'b0);
      end else begin
        cycle($urandom_range(0, 1) == 1, exp_idx % HR, exp_idx / HR, 24'($urandom),
              $urandom_range(0, 2) != 0, 1'b0);
      end
    end
    drain("rand_drain");
    idle(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
